// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, encodings and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_W    = 64;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_INST_W    = 32;
  localparam int ARB_LS_STREAK = 4;

  // Wide enough for streak limits up to 15.
  localparam int STREAK_W = 4;

  // Fetches and loads always read the full bus word.
  localparam logic [7:0] WMASK_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_prio.sv
// Owner selection between fetch and load/store, with a bounded LSU streak so
// a busy load/store stream cannot starve instruction fetch indefinitely.
module mem_bus_arbiter_prio
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LS_STREAK = ARB_LS_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_ls_req,
  input  logic i_grant,
  output logic o_pick_ls
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK);

  logic [STREAK_W-1:0] r_streak;

  // Combinational pick: LSU wins ties until it has used up its streak.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    o_pick_ls = 1'b0;
    if (i_ls_req && (!i_if_req || (r_streak != STREAK_MAX))) begin
      o_pick_ls = 1'b1;
    end
  end

  // Count consecutive LSU grants; saturate at the limit so the tie-break
  // comparison above stays exact, and clear on any fetch grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (i_grant) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!o_pick_ls) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// One bus transaction is in flight at a time: IDLE picks and latches,
// REQ holds the request until granted, WAIT collects the response.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int INST_W    = ARB_INST_W,
  parameter int LS_STREAK = ARB_LS_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [INST_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_re,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [7:0]        ls_wmask,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_finish,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wmask,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  logic              r_drop;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [7:0]        r_bus_wmask;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [INST_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_ls_finish;

  logic w_ls_any;
  logic w_start;
  logic w_pick_ls;
  logic w_if_flush_hit;

  // A store wins when both ls_re and ls_we are raised together.
  assign w_ls_any = ls_re | ls_we;

  // The cycle carrying a done pulse is a dead arbitration cycle: the finished
  // requester's still-high request is ignored, and the other side waits one
  // cycle too so a requester re-raising right after its pulse competes fairly.
  assign w_start = (r_state == ST_IDLE) && !r_if_valid && !r_ls_finish
                   && (if_req || w_ls_any);

  // A redirect only matters while a fetch owns the bus.
  assign w_if_flush_hit = if_flush && (r_owner == OWN_IF);

  mem_bus_arbiter_prio #(
    .LS_STREAK (LS_STREAK)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .i_if_req  (if_req),
    .i_ls_req  (w_ls_any),
    .i_grant   (w_start),
    .o_pick_ls (w_pick_ls)
  );

  // Transaction FSM with registered bus fields and registered response pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_drop      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wmask <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_finish <= 1'b0;
    end else begin
      r_if_valid  <= 1'b0;
      r_ls_finish <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (w_start) begin
            r_bus_req <= 1'b1;
            r_state   <= ST_REQ;
            if (w_pick_ls) begin
              r_owner     <= OWN_LS;
              r_bus_we    <= ls_we;
              r_bus_addr  <= ls_addr;
              r_bus_wmask <= ls_we ? ls_wmask : WMASK_ALL;
              r_bus_wdata <= ls_we ? ls_wdata : '0;
            end else begin
              r_owner     <= OWN_IF;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= if_addr;
              r_bus_wmask <= WMASK_ALL;
              r_bus_wdata <= '0;
            end
          end
        end
        ST_REQ: begin
          if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (bus_rvalid) begin
            r_state <= ST_IDLE;
            if (r_owner == OWN_LS) begin
              r_ls_finish <= 1'b1;
              r_ls_rdata  <= bus_rdata;
            end else if (!r_drop && !if_flush) begin
              // Word select uses the latched address; if_addr may have moved on.
              r_if_valid <= 1'b1;
              r_if_rdata <= r_bus_addr[2] ? bus_rdata[2*INST_W-1:INST_W]
                                          : bus_rdata[INST_W-1:0];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wmask = r_bus_wmask;
  assign bus_wdata = r_bus_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign ls_rdata  = r_ls_rdata;
  assign ls_finish = r_ls_finish;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a cycle-by-cycle vector table for
// lone fetch/store/load traffic, then hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        ls_re;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [7:0]  ls_wmask;
  logic [63:0] ls_wdata;
  logic [63:0] ls_rdata;
  logic        ls_finish;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wmask;
  logic [63:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .INST_W    (32),
    .LS_STREAK (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .ls_re      (ls_re),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wmask   (ls_wmask),
    .ls_wdata   (ls_wdata),
    .ls_rdata   (ls_rdata),
    .ls_finish  (ls_finish),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wmask  (bus_wmask),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  // Load and store together is illegal from the LSU.
  always @(posedge clk) begin
    if (rst) assert (!(ls_re && ls_we)) else $error("illegal ls_re and ls_we together");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        if_req;
    logic [63:0] if_addr;
    logic        ls_re;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [7:0]  ls_wmask;
    logic [63:0] ls_wdata;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [63:0] e_addr;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsf;
    logic [63:0] e_lsd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] Z     = 64'h0;
  localparam logic [63:0] A_IF  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] A_ST  = 64'h0000_0000_8000_2000;
  localparam logic [63:0] A_LD  = 64'h0000_0000_8000_1008;
  localparam logic [63:0] A_LD2 = 64'h0000_0000_8000_1010;
  localparam logic [63:0] D_ST  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] R_IF  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R_LD  = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] R_LD2 = 64'h0BAD_F00D_0000_0042;
  localparam logic [31:0] IFD   = 32'h1111_2222;

  function automatic vec_t mk(
    input logic if_req_i, input logic [63:0] if_addr_i,
    input logic ls_re_i, input logic ls_we_i, input logic [63:0] ls_addr_i,
    input logic [7:0] ls_wmask_i, input logic [63:0] ls_wdata_i,
    input logic gnt_i, input logic rvalid_i, input logic [63:0] rdata_i,
    input logic e_req_i, input logic e_we_i, input logic [63:0] e_addr_i,
    input logic [7:0] e_wmask_i, input logic [63:0] e_wdata_i,
    input logic e_ifv_i, input logic [31:0] e_ifd_i,
    input logic e_lsf_i, input logic [63:0] e_lsd_i);
    vec_t v;
    v.if_req = if_req_i;   v.if_addr = if_addr_i;
    v.ls_re = ls_re_i;     v.ls_we = ls_we_i;       v.ls_addr = ls_addr_i;
    v.ls_wmask = ls_wmask_i; v.ls_wdata = ls_wdata_i;
    v.gnt = gnt_i;         v.rvalid = rvalid_i;     v.rdata = rdata_i;
    v.e_req = e_req_i;     v.e_we = e_we_i;         v.e_addr = e_addr_i;
    v.e_wmask = e_wmask_i; v.e_wdata = e_wdata_i;
    v.e_ifv = e_ifv_i;     v.e_ifd = e_ifd_i;
    v.e_lsf = e_lsf_i;     v.e_lsd = e_lsd_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0;  if_addr = '0;  if_flush = 1'b0;
    ls_re = 1'b0;   ls_we = 1'b0;  ls_addr = '0;  ls_wmask = '0;  ls_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  // Wait (bounded) for bus_req, then grant after gnt_delay cycles and respond
  // the next cycle. Returns in the cycle where the done pulse is visible.
  task automatic bus_txn(input logic [63:0] rdata, input int gnt_delay,
                         output logic [63:0] addr, output logic ok);
    ok = 1'b0;
    addr = '0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (bus_req) ok = 1'b1;
    end
    if (!ok) return;
    addr = bus_addr;
    repeat (gnt_delay) tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = rdata;
    tick();
    bus_rvalid = 1'b0;
  endtask

  initial begin
    logic [63:0] t_addr;
    logic        t_ok;
    logic        exp_ls[6];

    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("reset bus_req", {63'd0, bus_req}, 64'd0);
    check("reset bus_addr", bus_addr, 64'd0);
    check("reset pulses", {62'd0, if_valid, ls_finish}, 64'd0);
    rst = 1'b1;
    tick();

    // Lone fetch, turnaround and stray handshakes; store with delayed grant
    // (LSU port fields perturbed while in REQ to show the bus fields are latched);
    // loads with the request held through the finish cycle.
    vecs.push_back(mk(1, A_IF, 0, 0, Z, 8'h00, Z, 1, 0, Z,    1, 0, A_IF, 8'hFF, Z, 0, 32'h0, 0, Z));
    vecs.push_back(mk(1, A_IF, 0, 0, Z, 8'h00, Z, 1, 0, Z,    0, 0, A_IF, 8'hFF, Z, 0, 32'h0, 0, Z));
    vecs.push_back(mk(1, A_IF, 0, 0, Z, 8'h00, Z, 0, 1, R_IF, 0, 0, A_IF, 8'hFF, Z, 1, IFD,   0, Z));
    vecs.push_back(mk(1, A_IF, 0, 0, Z, 8'h00, Z, 1, 1, R_IF, 0, 0, A_IF, 8'hFF, Z, 0, IFD,   0, Z));
    vecs.push_back(mk(0, Z,    0, 0, Z, 8'h00, Z, 0, 0, Z,    0, 0, A_IF, 8'hFF, Z, 0, IFD,   0, Z));
    vecs.push_back(mk(0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, 0, Z, 1, 1, A_ST, 8'h0F, D_ST, 0, IFD, 0, Z));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(0, Z, 0, 1, Z, 8'hF0, Z,     0, 0, Z, 1, 1, A_ST, 8'h0F, D_ST, 0, IFD, 0, Z));
    end
    vecs.push_back(mk(0, Z, 0, 1, A_ST, 8'h0F, D_ST, 1, 0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, IFD, 0, Z));
    vecs.push_back(mk(0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, 1, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, IFD, 1, Z));
    vecs.push_back(mk(0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, 0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, IFD, 0, Z));
    vecs.push_back(mk(0, Z, 0, 0, Z,    8'h00, Z,    0, 0, Z, 0, 1, A_ST, 8'h0F, D_ST, 0, IFD, 0, Z));
    vecs.push_back(mk(0, Z, 1, 0, A_LD,  8'h00, Z, 0, 0, Z,     1, 0, A_LD,  8'hFF, Z, 0, IFD, 0, Z));
    vecs.push_back(mk(0, Z, 1, 0, A_LD,  8'h00, Z, 1, 0, Z,     0, 0, A_LD,  8'hFF, Z, 0, IFD, 0, Z));
    vecs.push_back(mk(0, Z, 1, 0, A_LD,  8'h00, Z, 0, 1, R_LD,  0, 0, A_LD,  8'hFF, Z, 0, IFD, 1, R_LD));
    vecs.push_back(mk(0, Z, 1, 0, A_LD2, 8'h00, Z, 0, 0, Z,     0, 0, A_LD,  8'hFF, Z, 0, IFD, 0, R_LD));
    vecs.push_back(mk(0, Z, 1, 0, A_LD2, 8'h00, Z, 0, 0, Z,     1, 0, A_LD2, 8'hFF, Z, 0, IFD, 0, R_LD));
    vecs.push_back(mk(0, Z, 1, 0, A_LD2, 8'h00, Z, 1, 0, Z,     0, 0, A_LD2, 8'hFF, Z, 0, IFD, 0, R_LD));
    vecs.push_back(mk(0, Z, 1, 0, A_LD2, 8'h00, Z, 0, 1, R_LD2, 0, 0, A_LD2, 8'hFF, Z, 0, IFD, 1, R_LD2));
    vecs.push_back(mk(0, Z, 0, 0, Z,     8'h00, Z, 0, 0, Z,     0, 0, A_LD2, 8'hFF, Z, 0, IFD, 0, R_LD2));

    foreach (vecs[i]) begin
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
      ls_re = vecs[i].ls_re;     ls_we = vecs[i].ls_we;     ls_addr = vecs[i].ls_addr;
      ls_wmask = vecs[i].ls_wmask; ls_wdata = vecs[i].ls_wdata;
      bus_gnt = vecs[i].gnt;     bus_rvalid = vecs[i].rvalid; bus_rdata = vecs[i].rdata;
      tick();
      check($sformatf("v%0d bus_req", i), {63'd0, bus_req}, {63'd0, vecs[i].e_req});
      check($sformatf("v%0d bus_we", i), {63'd0, bus_we}, {63'd0, vecs[i].e_we});
      check($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_addr);
      check($sformatf("v%0d bus_wmask", i), {56'd0, bus_wmask}, {56'd0, vecs[i].e_wmask});
      if (vecs[i].e_we) check($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d if_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].e_ifv});
      check($sformatf("v%0d if_rdata", i), {32'd0, if_rdata}, {32'd0, vecs[i].e_ifd});
      check($sformatf("v%0d ls_finish", i), {63'd0, ls_finish}, {63'd0, vecs[i].e_lsf});
      check($sformatf("v%0d ls_rdata", i), ls_rdata, vecs[i].e_lsd);
    end
    clear_inputs();
    tick();

    // Reset asserted mid-transaction in WAIT clears all outputs at once.
    ls_re = 1'b1;
    ls_addr = 64'h0000_0000_8000_5000;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async rst bus_addr", bus_addr, 64'd0);
    check("async rst bus_wmask", {56'd0, bus_wmask}, 64'd0);
    check("async rst if_rdata", {32'd0, if_rdata}, 64'd0);
    check("async rst ls_rdata", ls_rdata, 64'd0);
    check("async rst ctl", {59'd0, bus_req, bus_we, if_valid, ls_finish, |bus_wdata}, 64'd0);
    clear_inputs();
    tick();
    rst = 1'b1;

    // A stray response in IDLE is ignored.
    bus_rvalid = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus_rvalid = 1'b0;
    check("stray rvalid pulses", {62'd0, if_valid, ls_finish}, 64'd0);

    // First request after reset issues cleanly (fetch, upper word).
    if_req = 1'b1;
    if_addr = 64'h0000_0000_8000_4004;
    bus_txn(64'h0123_4567_89AB_CDEF, 0, t_addr, t_ok);
    check("post-rst txn seen", {63'd0, t_ok}, 64'd1);
    check("post-rst addr", t_addr, 64'h0000_0000_8000_4004);
    check("post-rst if_valid", {63'd0, if_valid}, 64'd1);
    check("post-rst if_rdata", {32'd0, if_rdata}, 64'h0000_0000_0123_4567);
    if_req = 1'b0;
    tick();

    // Both requesters held: four LSU grants, then fetch, then LSU again.
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if_req = 1'b1;
    if_addr = 64'h0000_0000_8000_0200;
    ls_re = 1'b1;
    ls_addr = 64'h0000_0000_8000_3000;
    for (int k = 0; k < 6; k++) begin
      bus_txn(64'hCCCC_DDDD_EEEE_FFFF, 0, t_addr, t_ok);
      check($sformatf("streak%0d seen", k), {63'd0, t_ok}, 64'd1);
      check($sformatf("streak%0d owner addr", k), t_addr,
            exp_ls[k] ? 64'h0000_0000_8000_3000 : 64'h0000_0000_8000_0200);
      check($sformatf("streak%0d pulses", k), {62'd0, if_valid, ls_finish},
            {62'd0, !exp_ls[k], exp_ls[k]});
      if (!exp_ls[k]) check("streak if_rdata", {32'd0, if_rdata}, 64'h0000_0000_EEEE_FFFF);
    end
    clear_inputs();
    tick();

    // Flush during WAIT drops the stale fetch; the next fetch returns its own data.
    if_req = 1'b1;
    if_addr = 64'h0000_0000_8000_0040;
    tick();
    check("flush req", {63'd0, bus_req}, 64'd1);
    check("flush addr", bus_addr, 64'h0000_0000_8000_0040);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    if_flush = 1'b1;
    if_addr = 64'h0000_0000_8000_0100;
    tick();
    if_flush = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    tick();
    bus_rvalid = 1'b0;
    check("flush dropped if_valid", {63'd0, if_valid}, 64'd0);
    tick();
    check("refetch req", {63'd0, bus_req}, 64'd1);
    check("refetch addr", bus_addr, 64'h0000_0000_8000_0100);
    check("refetch no early pulse", {63'd0, if_valid}, 64'd0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 64'h5555_6666_7777_8888;
    tick();
    bus_rvalid = 1'b0;
    if_req = 1'b0;
    check("refetch if_valid", {63'd0, if_valid}, 64'd1);
    check("refetch if_rdata", {32'd0, if_rdata}, 64'h0000_0000_7777_8888);
    tick();
    check("refetch single pulse", {63'd0, if_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
